mem_bank_be: RTL and testbench

- Parametrised single-port synchronous data memory; successor to the fixed 1024x32 store/load memory.
- Adds configurable width and depth, per-byte write enables, and a selectable 1- or 2-cycle registered read with a valid strobe.
- Adds a hardware clear sequencer that zeroes the whole array after reset, with a busy flag.
- Sits on the CPU data-memory path: the memory stage drives addr, data and strobes, and consumes data_out qualified by rd_valid.

---
 rtl/mem_bank_be.sv | 157 +++++++++++++++
 tb/tb_mem_bank_be.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_bank_be.sv
// Single-port data memory with byte-lane writes, a 1- or 2-cycle registered read with valid strobe,
// and a post-reset clear sweep that zeroes the whole array before any access is accepted.
module mem_bank_be #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic                  sel,
    input  logic                  str,
    input  logic                  ld,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  busy
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range_s;
    logic                acc_s;
    logic                rd_s;
    logic                wr_s;
    logic                sweep_we_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [NB-1:0]       wr_be_s;
    logic [DATA_W-1:0]   rd_word_s;

    logic [DATA_W-1:0]   data_out_q;
    logic                rd_valid_q;

    // Access qualification and write-port steering between the sweep and CPU stores.
    always_comb begin
        in_range_s = ({1'b0, addr} < DEPTH_W);
        acc_s      = (state_q == ST_READY) && sel;
        rd_s       = acc_s && ld;
        wr_s       = acc_s && str && in_range_s;
        // The array must stay untouched while clr is held, so the sweep waits for release.
        sweep_we_s = (state_q == ST_SWEEP) && !clr;
        if (sweep_we_s) begin
            wr_addr_s = ptr_q;
            wr_data_s = {DATA_W{1'b0}};
            wr_be_s   = {NB{1'b1}};
        end else if (wr_s) begin
            wr_addr_s = addr;
            wr_data_s = data_in;
            wr_be_s   = byte_en;
        end else begin
            wr_addr_s = addr;
            wr_data_s = data_in;
            wr_be_s   = {NB{1'b0}};
        end
        if (in_range_s) begin
            rd_word_s = mem_q[addr];
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
    end

    // Byte-lane write port; reads sample the pre-edge word, giving read-first collisions.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be_s[i]) begin
                mem_q[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

    // Clear sequencer: one word per cycle from 0 to DEPTH-1, then READY.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_SWEEP;
            ptr_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_SWEEP: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q   <= ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_SWEEP;
                    ptr_q   <= {ADDR_W{1'b0}};
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            // Single read stage: data and strobe land on the accepting edge.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    data_out_q <= {DATA_W{1'b0}};
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_s;
                    if (rd_s) begin
                        data_out_q <= rd_word_s;
                    end
                end
            end
        end else begin : g_lat2
            logic              s1_valid_q;
            logic [DATA_W-1:0] s1_data_q;

            // Two read stages; clr flushes the in-flight stage so no stale strobe escapes.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= {DATA_W{1'b0}};
                    data_out_q <= {DATA_W{1'b0}};
                    rd_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= rd_s;
                    if (rd_s) begin
                        s1_data_q <= rd_word_s;
                    end
                    rd_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        data_out_q <= s1_data_q;
                    end
                end
            end
        end
    endgenerate

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bank_be.sv
// Scoreboard bench for mem_bank_be: two instances (1024 words/1-cycle read and
// 1000 words/2-cycle read) share stimulus; each has its own reference model and monitor.
module tb_mem_bank_be;

    typedef struct {
        logic [31:0] d;
        int          due;
    } ent_t;

    logic        clk;
    logic        clr;
    logic [9:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  byte_en;
    logic        sel;
    logic        str;
    logic        ld;

    int n_pass = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DEP = (g == 0) ? 1024 : 1000;
        localparam int LAT = (g == 0) ? 1 : 2;

        logic [31:0] dout;
        logic        rdv;
        logic        bsy;

        mem_bank_be #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEP), .READ_LAT(LAT)) dut (
            .clk(clk), .clr(clr), .addr(addr), .data_in(data_in), .byte_en(byte_en),
            .sel(sel), .str(str), .ld(ld), .data_out(dout), .rd_valid(rdv), .busy(bsy)
        );

        logic [31:0] mm [DEP];
        logic [31:0] v;
        logic [31:0] mask;
        logic [31:0] last = 32'h0;
        int          cnt = 0;
        int          ec = 0;
        ent_t        q[$];

        // reference model: clr discards pending reads and restarts the sweep count
        always @(posedge clr) begin
            q.delete();
            cnt = 0;
        end

        always @(posedge clk) begin
            ec = ec + 1;
            if (clr) begin
                q.delete();
                cnt = 0;
            end else begin
                if (cnt >= DEP && sel) begin
                    if (ld) begin
                        v = (int'(addr) < DEP) ? mm[int'(addr)] : 32'h0;
                        q.push_back('{d: v, due: ec + LAT - 1});
                    end
                    if (str && int'(addr) < DEP) begin
                        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{byte_en[b]}};
                        mm[int'(addr)] = (mm[int'(addr)] & ~mask) | (data_in & mask);
                    end
                end
                if (cnt < DEP) begin
                    cnt = cnt + 1;
                    if (cnt == DEP) foreach (mm[i]) mm[i] = 32'h0;
                end
            end
        end

        // monitor
        always @(negedge clk) begin
            if (clr) begin
                chk(dout == 32'h0, $sformatf("u%0d reset data_out", g), dout, 32'h0);
                chk(rdv == 1'b0, $sformatf("u%0d reset rd_valid", g), {31'h0, rdv}, 32'h0);
                chk(bsy == 1'b1, $sformatf("u%0d reset busy", g), {31'h0, bsy}, 32'h1);
                last = 32'h0;
            end else begin
                if (q.size() > 0 && q[0].due < ec) begin
                    chk(1'b0, $sformatf("u%0d overdue read", g), 32'(q[0].due), 32'(ec));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == ec) begin
                    chk(rdv == 1'b1, $sformatf("u%0d rd_valid pulse", g), {31'h0, rdv}, 32'h1);
                    last = q[0].d;
                    void'(q.pop_front());
                end else begin
                    chk(rdv == 1'b0, $sformatf("u%0d rd_valid idle", g), {31'h0, rdv}, 32'h0);
                end
                chk(dout == last, $sformatf("u%0d data_out", g), dout, last);
                chk(bsy == (cnt < DEP), $sformatf("u%0d busy", g), {31'h0, bsy}, {31'h0, (cnt < DEP)});
            end
        end
    end

    task automatic drive(input logic s, input logic w, input logic r, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        sel = s; str = w; ld = r; addr = a; data_in = d; byte_en = be;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [9:0] ra;
        clr = 1'b1;
        sel = 1'b0; str = 1'b0; ld = 1'b0; addr = 10'd0; data_in = 32'h0; byte_en = 4'h0;
        idle(2);
        clr = 1'b0;
        // write during busy must be dropped
        idle(3);
        drive(1'b1, 1'b1, 1'b1, 10'd0, 32'hFFFF_FFFF, 4'hF);
        idle(500);
        // restart the sweep mid-way
        clr = 1'b1;
        idle(2);
        clr = 1'b0;
        idle(1030);

        drive(1'b1, 1'b0, 1'b1, 10'd0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 10'd5, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 10'd1023, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 10'd3, 32'hDEAD_BEEF, 4'hF);
        drive(1'b1, 1'b0, 1'b1, 10'd3, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 10'd3, 32'h1122_3344, 4'h5);
        drive(1'b1, 1'b0, 1'b1, 10'd3, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 10'd7, 32'hAAAA_0000, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 10'd7, 32'h1234_5678, 4'hF);
        drive(1'b1, 1'b0, 1'b1, 10'd7, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 1'b1, 10'd7, 32'h5555_5555, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 10'd1010, 32'hCAFE_F00D, 4'hF);
        drive(1'b1, 1'b0, 1'b1, 10'd1010, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 10'd999, 32'h0BAD_CAFE, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 10'd999, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 10'd1000, 32'h0BAD_CAFE, 4'hF);
        drive(1'b1, 1'b0, 1'b1, 10'd1000, 32'h0, 4'h0);
        idle(3);

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 10'($urandom_range(0, 1023));
                1: ra = 10'($urandom_range(990, 1023));
                default: ra = 10'($urandom_range(0, 15));
            endcase
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ra, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(3);

        // clr one cycle after a load: the 2-cycle read must be discarded
        drive(1'b1, 1'b0, 1'b1, 10'd3, 32'h0, 4'h0);
        clr = 1'b1;
        idle(2);
        clr = 1'b0;
        idle(1030);
        drive(1'b1, 1'b0, 1'b1, 10'd3, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 10'd7, 32'h0, 4'h0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
